// File: rtl/lm32_ram_fifo_pkg.sv
// Shared lm32 read-side state encodings and the state type used by the RAM FIFO controller.
`ifndef LM32_RAM_FIFO_DEFS
`define LM32_RAM_FIFO_DEFS
`define LM32_FIFO_EMPTY 2'd0
`define LM32_FIFO_FETCH 2'd1
`define LM32_FIFO_READY 2'd2
`endif

package lm32_ram_fifo_pkg;
  typedef logic [1:0] fifo_state_t;
endpackage

// File: rtl/lm32_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-before-write on collision).
module lm32_dp_ram #(
  parameter int data_width = 32,
  parameter int addr_width = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [addr_width-1:0] waddr_i,
  input  logic [data_width-1:0] wdata_i,
  input  logic [addr_width-1:0] raddr_i,
  output logic [data_width-1:0] rdata_o
);

  logic [data_width-1:0] r_mem [0:(1<<addr_width)-1];
  logic [data_width-1:0] r_rdata;

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
    if (rst_i) r_rdata <= '0;
    else       r_rdata <= r_mem[raddr_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/lm32_ram_fifo.sv
// RAM-backed FIFO with a registered head word; the RAM read port prefetches so pops stream at 1/cycle.
module lm32_ram_fifo
  import lm32_ram_fifo_pkg::*;
#(
  parameter int data_width = 32,
  parameter int addr_width = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [data_width-1:0] wdata_i,
  output logic                  full_o,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [data_width-1:0] rdata_o,
  output logic [addr_width:0]   level_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 1 << addr_width;
  localparam logic [addr_width:0] FULL_CNT = (addr_width+1)'(DEPTH);

  fifo_state_t           r_state, w_state_nxt;
  logic [addr_width-1:0] r_wr_ptr, r_rd_ptr, w_raddr;
  logic [addr_width:0]   r_count;
  logic                  r_pf_vld, r_overflow, r_underflow;
  logic [data_width-1:0] r_rdata, w_ram_rdata;
  logic                  w_valid, w_full, w_push_acc, w_pop_acc, w_move;

  lm32_dp_ram #(.data_width(data_width), .addr_width(addr_width)) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (w_push_acc),
    .waddr_i (r_wr_ptr),
    .wdata_i (wdata_i),
    .raddr_i (w_raddr),
    .rdata_o (w_ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= `LM32_FIFO_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      `LM32_FIFO_EMPTY: if (r_count != '0) w_state_nxt = `LM32_FIFO_FETCH;
      `LM32_FIFO_FETCH: w_state_nxt = `LM32_FIFO_READY;
      `LM32_FIFO_READY: begin
        if (w_pop_acc) begin
          if (r_pf_vld)            w_state_nxt = `LM32_FIFO_READY;
          else if (r_count != '0)  w_state_nxt = `LM32_FIFO_FETCH;
          else                     w_state_nxt = `LM32_FIFO_EMPTY;
        end
      end
      default: w_state_nxt = `LM32_FIFO_EMPTY;
    endcase
    if (flush_i) w_state_nxt = `LM32_FIFO_EMPTY;
  end

  // r_count includes the prefetched word, so its RAM slot stays protected until it
  // moves into the output register; re-reading the head address each cycle is safe.
  always_comb begin
    w_valid    = (r_state == `LM32_FIFO_READY);
    w_full     = (r_count == FULL_CNT);
    w_push_acc = push_i && !w_full && !flush_i;
    w_pop_acc  = pop_i && w_valid && !flush_i;
    w_move     = r_pf_vld && ((r_state == `LM32_FIFO_FETCH) || w_pop_acc) && !flush_i;
    w_raddr    = w_move ? r_rd_ptr + addr_width'(1) : r_rd_ptr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pf_vld    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + addr_width'(1);
      if (w_move)     r_rd_ptr <= r_rd_ptr + addr_width'(1);
      r_count     <= r_count + (addr_width+1)'(w_push_acc) - (addr_width+1)'(w_move);
      // Head word was written before this edge iff it was already counted.
      r_pf_vld    <= (r_count > (addr_width+1)'(w_move));
      r_overflow  <= push_i && w_full;
      r_underflow <= pop_i && !w_valid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_move && !rst_i) r_rdata <= w_ram_rdata;
  end

  assign full_o      = w_full;
  assign valid_o     = w_valid;
  assign rdata_o     = r_rdata;
  assign level_o     = r_count + (addr_width+1)'(w_valid);
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

endmodule
